// File: rtl/cavlc_write_run_befores_pkg.sv
// Shared state encoding and width constants for the CAVLC run_before writer.
package cavlc_write_run_befores_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } rb_state_e;

  localparam int MAX_COEFF_LUMA = 16;
  localparam int MAX_COEFF_AC   = 15;
  localparam int MAX_COEFF_CDC  = 4;
  localparam int NUM_COEFF      = 16;
  localparam int CODE_W         = 11;
  localparam int LEN_W          = 4;

endpackage

// File: rtl/cavlc_write_run_befores_vlc.sv
// Combinational run_before codeword table indexed by (zeros_left, run).
module cavlc_run_before_vlc
  import cavlc_write_run_befores_pkg::*;
(
  input  logic [3:0]        zeros_left,
  input  logic [3:0]        run,
  output logic [CODE_W-1:0] code,
  output logic [LEN_W-1:0]  len
);

  logic [2:0] v;
  logic [3:0] l;

  always_comb begin
    v = '0;
    l = '0;
    // Pairs with run > zeros_left, or zeros_left == 0, stay at len 0.
    if (run <= zeros_left) begin
      case (zeros_left)
        4'd0: begin end
        4'd1: {v, l} = {2'b00, ~run[0], 4'd1};
        4'd2: case (run)
          4'd0:    {v, l} = {3'd1, 4'd1};
          4'd1:    {v, l} = {3'd1, 4'd2};
          default: {v, l} = {3'd0, 4'd2};
        endcase
        4'd3: {v, l} = {1'b0, 2'd3 - run[1:0], 4'd2};
        4'd4: case (run)
          4'd0:    {v, l} = {3'd3, 4'd2};
          4'd1:    {v, l} = {3'd2, 4'd2};
          4'd2:    {v, l} = {3'd1, 4'd2};
          4'd3:    {v, l} = {3'd1, 4'd3};
          default: {v, l} = {3'd0, 4'd3};
        endcase
        4'd5: case (run)
          4'd0:    {v, l} = {3'd3, 4'd2};
          4'd1:    {v, l} = {3'd2, 4'd2};
          4'd2:    {v, l} = {3'd3, 4'd3};
          4'd3:    {v, l} = {3'd2, 4'd3};
          4'd4:    {v, l} = {3'd1, 4'd3};
          default: {v, l} = {3'd0, 4'd3};
        endcase
        4'd6: case (run)
          4'd0:    {v, l} = {3'd3, 4'd2};
          4'd1:    {v, l} = {3'd0, 4'd3};
          4'd2:    {v, l} = {3'd1, 4'd3};
          4'd3:    {v, l} = {3'd3, 4'd3};
          4'd4:    {v, l} = {3'd2, 4'd3};
          4'd5:    {v, l} = {3'd5, 4'd3};
          default: {v, l} = {3'd4, 4'd3};
        endcase
        default: begin
          // Long runs become a zero prefix terminated by a single 1.
          if (run <= 4'd6) begin
            v = 3'(4'd7 - run);
            l = 4'd3;
          end else if (run <= 4'd14) begin
            v = 3'd1;
            l = run - 4'd3;
          end
        end
      endcase
    end
  end

  assign code = CODE_W'(v);
  assign len  = l;

endmodule

// File: rtl/cavlc_write_run_befores.sv
// CAVLC run_before writer: scans a latched block, then streams one codeword per handshake.
// Optional CAVLC_RB_BITCNT_EN adds a bit_count output totalling the emitted bits.
module cavlc_write_run_befores
  import cavlc_write_run_befores_pkg::*;
#(
  parameter int MAX_COEFF = 16,
  parameter int LEVEL_W   = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ena,
  input  logic                         start,
  input  logic [NUM_COEFF*LEVEL_W-1:0] coeff_bus,
  output logic [CODE_W-1:0]            code_out,
  output logic [LEN_W-1:0]             len_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4:0]                   total_coeff_out,
  output logic [3:0]                   total_zeros_out,
  output logic                         busy,
  output logic                         done
`ifdef CAVLC_RB_BITCNT_EN
  ,
  output logic [7:0]                   bit_count
`endif
);

  rb_state_e             state_q, state_d;
  logic [NUM_COEFF-1:0]  bus_nz, nz_mask;
  logic [3:0]            last_idx, tz_cnt, nxt_idx, run_len, zl_next;
  logic [4:0]            tc_cnt;
  logic [3:0]            pos_q, zeros_left_q;
  logic [4:0]            remain_q;
  logic [CODE_W-1:0]     vlc_code;
  logic [LEN_W-1:0]      vlc_len;
  logic                  hs;

  always_comb begin
    bus_nz = '0;
    for (int k = 0; k < NUM_COEFF; k++)
      if (k < MAX_COEFF) bus_nz[k] = |coeff_bus[LEVEL_W*k +: LEVEL_W];
  end

  // Scan stage: last nonzero index and nonzero count of the latched block.
  always_comb begin
    last_idx = '0;
    tc_cnt   = '0;
    for (int k = 0; k < NUM_COEFF; k++) begin
      if (nz_mask[k]) begin
        last_idx = 4'(k);
        tc_cnt   = tc_cnt + 5'd1;
      end
    end
    tz_cnt = (tc_cnt == 5'd0) ? 4'd0 : 4'({1'b0, last_idx} + 5'd1 - tc_cnt);
  end

  // Run stage: next lower nonzero coefficient and the zero run in between.
  always_comb begin
    nxt_idx = '0;
    for (int k = 0; k < NUM_COEFF; k++)
      if (nz_mask[k] && (4'(k) < pos_q)) nxt_idx = 4'(k);
    run_len = pos_q - nxt_idx - 4'd1;
    zl_next = zeros_left_q - run_len;
  end

  cavlc_run_before_vlc u_vlc (
    .zeros_left (zeros_left_q),
    .run        (run_len),
    .code       (vlc_code),
    .len        (vlc_len)
  );

  assign out_valid = (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign code_out  = out_valid ? vlc_code : '0;
  assign len_out   = out_valid ? vlc_len  : '0;
  assign hs        = out_valid && out_ready && ena;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && ena) state_d = ST_SCAN;
      ST_SCAN: if (ena) state_d = (tc_cnt <= 5'd1 || tz_cnt == 4'd0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (hs && (zl_next == 4'd0 || remain_q == 5'd2)) state_d = ST_DONE;
      ST_DONE: if (ena) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nz_mask         <= '0;
      pos_q           <= '0;
      zeros_left_q    <= '0;
      remain_q        <= '0;
      total_coeff_out <= '0;
      total_zeros_out <= '0;
`ifdef CAVLC_RB_BITCNT_EN
      bit_count       <= '0;
`endif
    end else if (ena) begin
      case (state_q)
        ST_IDLE: if (start) nz_mask <= bus_nz;
        ST_SCAN: begin
          total_coeff_out <= tc_cnt;
          total_zeros_out <= tz_cnt;
          pos_q           <= last_idx;
          zeros_left_q    <= tz_cnt;
          remain_q        <= tc_cnt;
`ifdef CAVLC_RB_BITCNT_EN
          bit_count       <= '0;
`endif
        end
        ST_RUN: if (out_ready) begin
          pos_q        <= nxt_idx;
          zeros_left_q <= zl_next;
          remain_q     <= remain_q - 5'd1;
`ifdef CAVLC_RB_BITCNT_EN
          bit_count    <= bit_count + 8'(len_out);
`endif
        end
        default: begin end
      endcase
    end
  end

endmodule

// File: tb/tb_cavlc_write_run_befores.sv
// Randomized self-checking bench for cavlc_write_run_befores with a list-based reference model.
module tb_cavlc_write_run_befores;

  localparam int LEVEL_W = 9;

  logic                  clk = 1'b0;
  logic                  rst, ena, start, out_ready;
  logic [16*LEVEL_W-1:0] coeff_bus;
  logic [10:0]           code_out;
  logic [3:0]            len_out;
  logic                  out_valid, busy, done;
  logic [4:0]            total_coeff_out;
  logic [3:0]            total_zeros_out;
`ifdef CAVLC_RB_BITCNT_EN
  logic [7:0]            bit_count;
`endif

  cavlc_write_run_befores #(.MAX_COEFF(16), .LEVEL_W(LEVEL_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .ena             (ena),
    .start           (start),
    .coeff_bus       (coeff_bus),
    .code_out        (code_out),
    .len_out         (len_out),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .total_coeff_out (total_coeff_out),
    .total_zeros_out (total_zeros_out),
    .busy            (busy),
    .done            (done)
`ifdef CAVLC_RB_BITCNT_EN
    ,
    .bit_count       (bit_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [LEVEL_W-1:0] blk [16];
  logic [10:0] exp_code [$];
  logic [3:0]  exp_len [$];
  int exp_tc, exp_tz, exp_bits;

  // Codeword strings straight from the run_before table, first bit leftmost.
  function automatic string vlc_str(int zl, int run);
    string s;
    s = "";
    if (zl >= 1 && run >= 0 && run <= zl) begin
      case (zl)
        1: s = (run == 0) ? "1" : "0";
        2: s = (run == 0) ? "1" : (run == 1) ? "01" : "00";
        3: s = (run == 0) ? "11" : (run == 1) ? "10" : (run == 2) ? "01" : "00";
        4: s = (run == 0) ? "11" : (run == 1) ? "10" : (run == 2) ? "01" : (run == 3) ? "001" : "000";
        5: s = (run == 0) ? "11" : (run == 1) ? "10" : (run == 2) ? "011" :
               (run == 3) ? "010" : (run == 4) ? "001" : "000";
        6: s = (run == 0) ? "11" : (run == 1) ? "000" : (run == 2) ? "001" : (run == 3) ? "011" :
               (run == 4) ? "010" : (run == 5) ? "101" : "100";
        default: begin
          if (run <= 6) begin
            s = (run == 0) ? "111" : (run == 1) ? "110" : (run == 2) ? "101" : (run == 3) ? "100" :
                (run == 4) ? "011" : (run == 5) ? "010" : "001";
          end else begin
            for (int i = 0; i < run - 4; i++) s = {s, "0"};
            s = {s, "1"};
          end
        end
      endcase
    end
    return s;
  endfunction

  task automatic build_model();
    int idx [$];
    int zl, run, c;
    string s;
    idx = {};
    for (int k = 15; k >= 0; k--) if (blk[k] != '0) idx.push_back(k);
    exp_code.delete();
    exp_len.delete();
    exp_bits = 0;
    exp_tc = idx.size();
    exp_tz = (exp_tc == 0) ? 0 : idx[0] + 1 - exp_tc;
    if (exp_tc >= 2 && exp_tz > 0) begin
      zl = exp_tz;
      for (int i = 0; i < exp_tc - 1; i++) begin
        run = idx[i] - idx[i+1] - 1;
        s = vlc_str(zl, run);
        c = 0;
        for (int j = 0; j < s.len(); j++) c = c * 2 + ((s.getc(j) == "1") ? 1 : 0);
        exp_code.push_back(11'(c));
        exp_len.push_back(4'(s.len()));
        exp_bits += s.len();
        zl -= run;
        if (zl == 0) break;
      end
    end
  endtask

  // mode 0: always ready; 1: random ready; 2: first 3 valid cycles stalled with start pulsed.
  task automatic run_block(input string name, input int mode);
    int cyc, first_valid, done_at, stall_n, n_exp;
    logic held, rdy;
    logic [10:0] hcode;
    logic [3:0] hlen;
    build_model();
    n_exp = exp_code.size();
    @(negedge clk);
    for (int k = 0; k < 16; k++) coeff_bus[LEVEL_W*k +: LEVEL_W] = blk[k];
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    coeff_bus = {16*LEVEL_W{1'b1}};
    first_valid = -1;
    done_at = -1;
    held = 1'b0;
    stall_n = 0;
    hcode = '0;
    hlen = '0;
    for (cyc = 0; cyc < 200; cyc++) begin
      if (done) begin
        done_at = cyc;
        break;
      end
      start = 1'b0;
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (held) begin
          checks++;
          if (code_out !== hcode || len_out !== hlen) begin
            errors++;
            $display("FAIL %s stall_stable: code=%h len=%0d, required code=%h len=%0d",
                     name, code_out, len_out, hcode, hlen);
          end
        end
        checks++;
        if (exp_code.size() == 0) begin
          errors++;
          $display("FAIL %s extra_codeword: code=%h len=%0d, required none", name, code_out, len_out);
        end else if (code_out !== exp_code[0] || len_out !== exp_len[0]) begin
          errors++;
          $display("FAIL %s codeword: code=%h len=%0d, required code=%h len=%0d",
                   name, code_out, len_out, exp_code[0], exp_len[0]);
        end
        rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (stall_n >= 3);
        if (mode == 2 && !rdy) begin
          stall_n++;
          start = 1'b1;
        end
        out_ready = rdy;
        if (rdy) begin
          if (exp_code.size() > 0) begin
            void'(exp_code.pop_front());
            void'(exp_len.pop_front());
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
          hcode = code_out;
          hlen = len_out;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (done_at < 0) begin
      errors++;
      $display("FAIL %s done_timeout: no done within 200 cycles, required done", name);
    end
    checks++;
    if (exp_code.size() != 0) begin
      errors++;
      $display("FAIL %s missing_codewords: %0d left, required 0", name, exp_code.size());
    end
    checks++;
    if (total_coeff_out !== 5'(exp_tc) || total_zeros_out !== 4'(exp_tz)) begin
      errors++;
      $display("FAIL %s totals: tc=%0d tz=%0d, required tc=%0d tz=%0d",
               name, total_coeff_out, total_zeros_out, exp_tc, exp_tz);
    end
    checks++;
    if (n_exp > 0 && first_valid != 1) begin
      errors++;
      $display("FAIL %s first_valid_latency: %0d, required 1", name, first_valid);
    end else if (n_exp == 0 && (first_valid != -1 || done_at != 1)) begin
      errors++;
      $display("FAIL %s empty_block: first_valid=%0d done_at=%0d, required -1 and 1",
               name, first_valid, done_at);
    end
`ifdef CAVLC_RB_BITCNT_EN
    checks++;
    if (bit_count !== 8'(exp_bits)) begin
      errors++;
      $display("FAIL %s bit_count: %0d, required %0d", name, bit_count, exp_bits);
    end
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b, required 0 0", name, done, busy);
    end
  endtask

  task automatic clear_blk();
    for (int k = 0; k < 16; k++) blk[k] = '0;
  endtask

  task automatic set_first_block();
    clear_blk();
    blk[0] = 9'd3;
    blk[2] = 9'h1FF;
    blk[5] = 9'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ena = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    coeff_bus = '0;
    #12;
    checks++;
    if (code_out !== '0 || len_out !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        total_coeff_out !== '0 || total_zeros_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: code=%h len=%0d vld=%b busy=%b done=%b tc=%0d tz=%0d, required all 0",
               code_out, len_out, out_valid, busy, done, total_coeff_out, total_zeros_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    set_first_block();
    run_block("first_block", 0);
    clear_blk();
    run_block("all_zero", 0);
    clear_blk();
    blk[15] = 9'd7;
    run_block("single_15", 0);
    clear_blk();
    blk[14] = 9'h100;
    blk[0] = 9'd1;
    run_block("idx14_idx0", 0);
  endtask

  task automatic test_backpressure();
    set_first_block();
    run_block("backpressure", 2);
  endtask

  task automatic test_rst_mid_block();
    int w;
    logic seen_done;
    set_first_block();
    @(negedge clk);
    for (int k = 0; k < 16; k++) coeff_bus[LEVEL_W*k +: LEVEL_W] = blk[k];
    start = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL rst_mid reach_run: out_valid=%b, required 1", out_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (code_out !== '0 || len_out !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        total_coeff_out !== '0 || total_zeros_out !== '0) begin
      errors++;
      $display("FAIL rst_mid outputs: code=%h len=%0d vld=%b busy=%b done=%b tc=%0d tz=%0d, required all 0",
               code_out, len_out, out_valid, busy, done, total_coeff_out, total_zeros_out);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL rst_mid no_done: done/busy seen=%b, required 0", seen_done);
    end
    run_block("after_rst", 0);
  endtask

  task automatic test_random();
    int dens;
    for (int b = 0; b < 40; b++) begin
      dens = $urandom_range(0, 4);
      for (int k = 0; k < 16; k++)
        blk[k] = ($urandom_range(0, 4) < dens) ? 9'($urandom_range(1, 511)) : 9'd0;
      run_block("random", 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_rst_mid_block();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
